// File: rtl/viterbi_acs_front_if.sv
// rtl/viterbi_acs_front_if.sv - symbol-in / frame-out bundle of the Viterbi ACS front end
interface viterbi_acs_front_if #(
   parameter int SW  = 8,
   parameter int PMW = 8
) ();
   logic           in_valid;
   logic           in_ready;
   logic [SW-1:0]  ra;
   logic [SW-1:0]  rb;
   logic           out_valid;
   logic           out_ready;
   logic [PMW-1:0] pm_s0;
   logic [PMW-1:0] pm_s1;
   logic [PMW-1:0] pm_s2;
   logic [PMW-1:0] pm_s3;
   logic [5:0]     surv_s0;
   logic [5:0]     surv_s1;
   logic [5:0]     surv_s2;
   logic [5:0]     surv_s3;
   logic [SW-1:0]  r7;
   logic [SW-1:0]  r8;

   modport master (
      output in_valid, ra, rb, out_ready,
      input  in_ready, out_valid, pm_s0, pm_s1, pm_s2, pm_s3,
             surv_s0, surv_s1, surv_s2, surv_s3, r7, r8
   );

   modport slave (
      input  in_valid, ra, rb, out_ready,
      output in_ready, out_valid, pm_s0, pm_s1, pm_s2, pm_s3,
             surv_s0, surv_s1, surv_s2, surv_s3, r7, r8
   );
endinterface

// File: rtl/viterbi_acs_front.sv
// rtl/viterbi_acs_front.sv - three-step 4-state ACS (K=3, 7/5) with fourth-pair capture
// Frame result is held until the final-stage decision block takes it.
module viterbi_acs_front #(
   parameter int SW  = 8,
   parameter int PMW = 8
) (
   input  logic               CLK,
   input  logic               RST_N,
   viterbi_acs_front_if.slave bus
);
   typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

   localparam logic [PMW-1:0] PM_MAX = '1;

   function automatic logic [5:0] bit_cost(input logic exp_one, input logic [SW-1:0] r);
      return 6'((exp_one ? ~r : r) >> (SW - 6));
   endfunction

   function automatic logic [6:0] branch(input logic [1:0] c, input logic [SW-1:0] a,
                                         input logic [SW-1:0] b);
      return {1'b0, bit_cost(c[1], a)} + {1'b0, bit_cost(c[0], b)};
   endfunction

   function automatic logic [PMW-1:0] sat_add(input logic [PMW-1:0] pm, input logic [6:0] bm);
      logic [PMW:0] sum;
      sum = {1'b0, pm} + {{(PMW-6){1'b0}}, bm};
      return sum[PMW] ? PM_MAX : sum[PMW-1:0];
   endfunction

   function automatic logic [1:0] coded(input logic u, input logic p1, input logic p0);
      return {u ^ p1 ^ p0, u ^ p0};
   endfunction

   state_t         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [PMW-1:0] pm_q [4];
   logic [PMW-1:0] pm_d [4];
   logic [PMW-1:0] acs_pm [4];
   logic [5:0]     surv_q [4];
   logic [5:0]     surv_d [4];
   logic [5:0]     acs_surv [4];
   logic [SW-1:0]  r7_q, r7_d;
   logic [SW-1:0]  r8_q, r8_d;

   // State {a,b} is reached from {b,0} and {b,1} with input a; the p0=0 predecessor wins ties.
   for (genvar g = 0; g < 4; g++) begin : g_acs
      localparam int A = g / 2;
      localparam int B = g % 2;
      localparam logic [1:0] P_LO = 2'(2 * B);
      localparam logic [1:0] P_HI = 2'(2 * B + 1);

      logic [1:0]     c_lo, c_hi;
      logic [PMW-1:0] cand_lo, cand_hi;
      logic           pick_hi;

      assign c_lo     = coded(1'(A), 1'(B), 1'b0);
      assign c_hi     = coded(1'(A), 1'(B), 1'b1);
      assign cand_lo  = sat_add(pm_q[P_LO], branch(c_lo, bus.ra, bus.rb));
      assign cand_hi  = sat_add(pm_q[P_HI], branch(c_hi, bus.ra, bus.rb));
      assign pick_hi  = cand_hi < cand_lo;
      assign acs_pm[g]   = pick_hi ? cand_hi : cand_lo;
      assign acs_surv[g] = pick_hi ? {surv_q[P_HI][3:0], c_hi} : {surv_q[P_LO][3:0], c_lo};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pm_d    = pm_q;
      surv_d  = surv_q;
      r7_d    = r7_q;
      r8_d    = r8_q;
      case (state_q)
         ST_ACC: begin
            if (bus.in_valid) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  r7_d    = bus.ra;
                  r8_d    = bus.rb;
                  state_d = ST_HOLD;
               end else begin
                  pm_d   = acs_pm;
                  surv_d = acs_surv;
               end
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               state_d = ST_ACC;
               cnt_d   = 2'd0;
               for (int s = 0; s < 4; s++) begin
                  pm_d[s]   = (s == 0) ? '0 : PM_MAX;
                  surv_d[s] = '0;
               end
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= ST_ACC;
         cnt_q   <= 2'd0;
         for (int s = 0; s < 4; s++) begin
            pm_q[s]   <= (s == 0) ? '0 : PM_MAX;
            surv_q[s] <= '0;
         end
         r7_q <= '0;
         r8_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pm_q    <= pm_d;
         surv_q  <= surv_d;
         r7_q    <= r7_d;
         r8_q    <= r8_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_ACC);
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.pm_s0     = pm_q[0];
   assign bus.pm_s1     = pm_q[1];
   assign bus.pm_s2     = pm_q[2];
   assign bus.pm_s3     = pm_q[3];
   assign bus.surv_s0   = surv_q[0];
   assign bus.surv_s1   = surv_q[1];
   assign bus.surv_s2   = surv_q[2];
   assign bus.surv_s3   = surv_q[3];
   assign bus.r7        = r7_q;
   assign bus.r8        = r8_q;
endmodule
